// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback.
// Outputs decode from state (plus MemReady/Zero); memory waits on MemReady and faults after MEM_TIMEOUT idle cycles.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [2:0] ALUOp,
  output logic       InstrRetired,
  output logic       Illegal,
  output logic       MemFault
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, JALR, JALRLINK, UPPER, HALT
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);

  state_t           state, nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_st, timeout, shift_op, set_illegal;
  logic             pc_w, mem_rd, mem_wr, ir_w, reg_w, retire;
  logic             unused_funct7b5;

  assign unused_funct7b5 = funct7b5;

  always_comb begin
    wait_st     = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
    // A MemReady arriving in the timeout cycle still completes the access.
    timeout     = (MEM_TIMEOUT > 0) && wait_st && !MemReady && (wait_cnt == TIMEOUT);
    shift_op    = (funct3 == 3'b001) || (funct3 == 3'b101);
    nxt         = state;
    set_illegal = 1'b0;
    pc_w        = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    ir_w        = 1'b0;
    reg_w       = 1'b0;
    retire      = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 3'b000;
    case (state)
      FETCH: begin
        mem_rd    = !timeout;
        ResultSrc = 2'b10;
        ALUSrcB   = 2'b10;
        if (timeout) nxt = HALT;
        else if (MemReady) begin
          ir_w = 1'b1;
          pc_w = 1'b1;
          nxt  = DECODE;
        end
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: nxt = MEMADR;
          7'b0110011:             nxt = EXECR;
          7'b0010011:             nxt = EXECI;
          7'b1100011:             nxt = BRANCH;
          7'b1101111:             nxt = JAL;
          7'b1100111: begin
            if (funct3 == 3'b000) nxt = JALR;
            else begin
              nxt         = HALT;
              set_illegal = 1'b1;
            end
          end
          7'b0110111, 7'b0010111: nxt = UPPER;
          default: begin
            nxt         = HALT;
            set_illegal = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        nxt     = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        mem_rd = !timeout;
        if (timeout) nxt = HALT;
        else if (MemReady) nxt = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
        retire    = 1'b1;
        nxt       = FETCH;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_wr = !timeout;
        if (timeout) nxt = HALT;
        else if (MemReady) begin
          retire = 1'b1;
          nxt    = FETCH;
        end
      end
      EXECR, EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = (state == EXECI) ? 2'b01 : 2'b00;
        ALUOp   = shift_op ? 3'b011 : 3'b010;
        nxt     = ALUWB;
      end
      ALUWB: begin
        reg_w  = 1'b1;
        retire = 1'b1;
        nxt    = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 3'b001;
        case (funct3)
          3'b000: begin
            pc_w   = Zero;
            retire = 1'b1;
            nxt    = FETCH;
          end
          3'b001: begin
            pc_w   = !Zero;
            retire = 1'b1;
            nxt    = FETCH;
          end
          default: begin
            nxt         = HALT;
            set_illegal = 1'b1;
          end
        endcase
      end
      JAL: begin
        pc_w    = 1'b1;
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        nxt     = ALUWB;
      end
      JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pc_w      = 1'b1;
        nxt       = JALRLINK;
      end
      JALRLINK: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        nxt     = ALUWB;
      end
      UPPER: begin
        ALUSrcB = 2'b01;
        if (op[5]) ALUOp = 3'b100;
        else ALUSrcA = 2'b01;
        nxt = ALUWB;
      end
      default: nxt = HALT;
    endcase
  end

  assign PCWrite      = reset & pc_w;
  assign MemRead      = reset & mem_rd;
  assign MemWrite     = reset & mem_wr;
  assign IRWrite      = reset & ir_w;
  assign RegWrite     = reset & reg_w;
  assign InstrRetired = reset & retire;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= FETCH;
      wait_cnt <= '0;
      Illegal  <= 1'b0;
      MemFault <= 1'b0;
    end else begin
      state <= nxt;
      if (set_illegal) Illegal <= 1'b1;
      if (timeout) MemFault <= 1'b1;
      if (wait_st && (nxt == state) && !MemReady) wait_cnt <= wait_cnt + CNT_W'(1);
      else wait_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle output vectors checked against hand-derived tables.
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, InstrRetired, Illegal, MemFault;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUOp;
  logic [17:0] outs;
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite), .ALUOp(ALUOp),
    .InstrRetired(InstrRetired), .Illegal(Illegal), .MemFault(MemFault)
  );

  // {PCWrite,AdrSrc,MemRead,MemWrite,IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite, ALUOp, InstrRetired, Illegal, MemFault}
  assign outs = {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                 RegWrite, ALUOp, InstrRetired, Illegal, MemFault};

  localparam logic [15:0] F_RDY    = {5'b10101, 2'b10, 2'b00, 2'b10, 1'b0, 3'b000, 1'b0};
  localparam logic [15:0] F_WAIT   = {5'b00100, 2'b10, 2'b00, 2'b10, 1'b0, 3'b000, 1'b0};
  localparam logic [15:0] F_QUIET  = {5'b00000, 2'b10, 2'b00, 2'b10, 1'b0, 3'b000, 1'b0};
  localparam logic [15:0] DEC      = {5'b00000, 2'b00, 2'b01, 2'b01, 1'b0, 3'b000, 1'b0};
  localparam logic [15:0] EXR_ALU  = {5'b00000, 2'b00, 2'b10, 2'b00, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] EXR_SH   = {5'b00000, 2'b00, 2'b10, 2'b00, 1'b0, 3'b011, 1'b0};
  localparam logic [15:0] EXI_ALU  = {5'b00000, 2'b00, 2'b10, 2'b01, 1'b0, 3'b010, 1'b0};
  localparam logic [15:0] EXI_SH   = {5'b00000, 2'b00, 2'b10, 2'b01, 1'b0, 3'b011, 1'b0};
  localparam logic [15:0] ALUWB_V  = {5'b00000, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 1'b1};
  localparam logic [15:0] UPR_LUI  = {5'b00000, 2'b00, 2'b00, 2'b01, 1'b0, 3'b100, 1'b0};
  localparam logic [15:0] UPR_AUI  = {5'b00000, 2'b00, 2'b01, 2'b01, 1'b0, 3'b000, 1'b0};
  localparam logic [15:0] JAL_V    = {5'b10000, 2'b00, 2'b01, 2'b10, 1'b0, 3'b000, 1'b0};
  localparam logic [15:0] JALR_V   = {5'b10000, 2'b10, 2'b10, 2'b01, 1'b0, 3'b000, 1'b0};
  localparam logic [15:0] LINK_V   = {5'b00000, 2'b00, 2'b01, 2'b10, 1'b0, 3'b000, 1'b0};
  localparam logic [15:0] BR_PC    = {5'b10000, 2'b00, 2'b10, 2'b00, 1'b0, 3'b001, 1'b1};
  localparam logic [15:0] BR_NOPC  = {5'b00000, 2'b00, 2'b10, 2'b00, 1'b0, 3'b001, 1'b1};
  localparam logic [15:0] BR_ILL   = {5'b00000, 2'b00, 2'b10, 2'b00, 1'b0, 3'b001, 1'b0};
  localparam logic [15:0] HALT_V   = 16'h0000;
  localparam logic [15:0] MADR     = {5'b00000, 2'b00, 2'b10, 2'b01, 1'b0, 3'b000, 1'b0};
  localparam logic [15:0] MRD_V    = {5'b01100, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0};
  localparam logic [15:0] MWB_V    = {5'b00000, 2'b01, 2'b00, 2'b00, 1'b1, 3'b000, 1'b1};
  localparam logic [15:0] MWR_W    = {5'b01010, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0};
  localparam logic [15:0] MWR_DONE = {5'b01010, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b1};
  localparam logic [15:0] MWR_RST  = {5'b01000, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0};

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR = 7'b1100011, OP_LD = 7'b0000011, OP_ST = 7'b0100011;

  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic        zero;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [17:0] exp;
  } step_t;

  function automatic step_t s(input logic r, input logic y, input logic z, input logic [6:0] o,
                              input logic [2:0] f, input logic [15:0] v, input logic [1:0] fl);
    step_t t;
    t.rst = r; t.rdy = y; t.zero = z; t.op = o; t.f3 = f; t.exp = {v, fl};
    return t;
  endfunction

  task automatic apply_reset();
    reset = 1'b0;
    MemReady = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    MemReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (outs !== {F_QUIET, 2'b00}) begin
        fails++;
        $display("FAIL reset cycle %0d: got %b expected %b", i, outs, {F_QUIET, 2'b00});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_alu();
    logic [6:0]  ops [6];
    logic [2:0]  f3s [6];
    logic [15:0] xv  [6];
    logic [17:0] e;
    ops = '{OP_R, OP_R, OP_I, OP_I, OP_LUI, OP_AUI};
    f3s = '{3'b000, 3'b001, 3'b101, 3'b010, 3'b000, 3'b000};
    xv  = '{EXR_ALU, EXR_SH, EXI_SH, EXI_ALU, UPR_LUI, UPR_AUI};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (i == 6 && k > 0) break;
        op = (i < 6) ? ops[i] : OP_R;
        funct3 = (i < 6) ? f3s[i] : 3'b000;
        MemReady = 1'b1;
        Zero = 1'b0;
        #1;
        e = {(k == 0) ? F_RDY : (k == 1) ? DEC : (k == 2) ? xv[i] : ALUWB_V, 2'b00};
        checks++;
        if (outs !== e) begin
          fails++;
          $display("FAIL alu instr %0d cycle %0d: got %b expected %b", i, k, outs, e);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_jump();
    step_t tv[$];
    tv.push_back(s(1, 1, 0, OP_JAL, 3'b000, F_RDY, 2'b00));
    tv.push_back(s(1, 1, 0, OP_JAL, 3'b000, DEC, 2'b00));
    tv.push_back(s(1, 1, 0, OP_JAL, 3'b000, JAL_V, 2'b00));
    tv.push_back(s(1, 1, 0, OP_JAL, 3'b000, ALUWB_V, 2'b00));
    tv.push_back(s(1, 1, 0, OP_JALR, 3'b000, F_RDY, 2'b00));
    tv.push_back(s(1, 1, 0, OP_JALR, 3'b000, DEC, 2'b00));
    tv.push_back(s(1, 1, 0, OP_JALR, 3'b000, JALR_V, 2'b00));
    tv.push_back(s(1, 1, 0, OP_JALR, 3'b000, LINK_V, 2'b00));
    tv.push_back(s(1, 1, 0, OP_JALR, 3'b000, ALUWB_V, 2'b00));
    tv.push_back(s(1, 1, 0, OP_JALR, 3'b001, F_RDY, 2'b00));
    tv.push_back(s(1, 1, 0, OP_JALR, 3'b001, DEC, 2'b00));
    tv.push_back(s(1, 1, 0, OP_JALR, 3'b001, HALT_V, 2'b10));
    tv.push_back(s(1, 1, 0, OP_JALR, 3'b000, HALT_V, 2'b10));
    apply_reset();
    for (int i = 0; i < tv.size(); i++) begin
      reset = tv[i].rst; MemReady = tv[i].rdy; Zero = tv[i].zero; op = tv[i].op; funct3 = tv[i].f3;
      #1;
      checks++;
      if (outs !== tv[i].exp) begin
        fails++;
        $display("FAIL jump step %0d: got %b expected %b", i, outs, tv[i].exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    step_t tv[$];
    logic [2:0]  bf [5];
    logic        bz [5];
    logic [15:0] bv [5];
    bf = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b100};
    bz = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    bv = '{BR_PC, BR_NOPC, BR_PC, BR_NOPC, BR_ILL};
    for (int i = 0; i < 5; i++) begin
      tv.push_back(s(1, 1, bz[i], OP_BR, bf[i], F_RDY, 2'b00));
      tv.push_back(s(1, 1, bz[i], OP_BR, bf[i], DEC, 2'b00));
      tv.push_back(s(1, 1, bz[i], OP_BR, bf[i], bv[i], 2'b00));
    end
    tv.push_back(s(1, 1, 1, OP_BR, 3'b000, HALT_V, 2'b10));
    apply_reset();
    for (int i = 0; i < tv.size(); i++) begin
      reset = tv[i].rst; MemReady = tv[i].rdy; Zero = tv[i].zero; op = tv[i].op; funct3 = tv[i].f3;
      #1;
      checks++;
      if (outs !== tv[i].exp) begin
        fails++;
        $display("FAIL branch step %0d: got %b expected %b", i, outs, tv[i].exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_store();
    step_t tv[$];
    tv.push_back(s(1, 1, 0, OP_LD, 3'b010, F_RDY, 2'b00));
    tv.push_back(s(1, 1, 0, OP_LD, 3'b010, DEC, 2'b00));
    tv.push_back(s(1, 1, 0, OP_LD, 3'b010, MADR, 2'b00));
    tv.push_back(s(1, 0, 0, OP_LD, 3'b010, MRD_V, 2'b00));
    tv.push_back(s(1, 0, 0, OP_LD, 3'b010, MRD_V, 2'b00));
    tv.push_back(s(1, 0, 0, OP_LD, 3'b010, MRD_V, 2'b00));
    tv.push_back(s(1, 1, 0, OP_LD, 3'b010, MRD_V, 2'b00));
    tv.push_back(s(1, 1, 0, OP_LD, 3'b010, MWB_V, 2'b00));
    tv.push_back(s(1, 1, 0, OP_ST, 3'b010, F_RDY, 2'b00));
    tv.push_back(s(1, 1, 0, OP_ST, 3'b010, DEC, 2'b00));
    tv.push_back(s(1, 1, 0, OP_ST, 3'b010, MADR, 2'b00));
    tv.push_back(s(1, 0, 0, OP_ST, 3'b010, MWR_W, 2'b00));
    tv.push_back(s(1, 1, 0, OP_ST, 3'b010, MWR_DONE, 2'b00));
    tv.push_back(s(1, 1, 0, OP_ST, 3'b010, F_RDY, 2'b00));
    tv.push_back(s(1, 1, 0, OP_ST, 3'b010, DEC, 2'b00));
    tv.push_back(s(1, 1, 0, OP_ST, 3'b010, MADR, 2'b00));
    tv.push_back(s(1, 0, 0, OP_ST, 3'b010, MWR_W, 2'b00));
    tv.push_back(s(0, 0, 0, OP_ST, 3'b010, MWR_RST, 2'b00));
    tv.push_back(s(1, 0, 0, 7'b0000000, 3'b000, F_WAIT, 2'b00));
    tv.push_back(s(1, 1, 0, 7'b0000000, 3'b000, F_RDY, 2'b00));
    tv.push_back(s(1, 1, 0, 7'b0000000, 3'b000, DEC, 2'b00));
    tv.push_back(s(1, 1, 0, 7'b0000000, 3'b000, HALT_V, 2'b10));
    apply_reset();
    for (int i = 0; i < tv.size(); i++) begin
      reset = tv[i].rst; MemReady = tv[i].rdy; Zero = tv[i].zero; op = tv[i].op; funct3 = tv[i].f3;
      #1;
      checks++;
      if (outs !== tv[i].exp) begin
        fails++;
        $display("FAIL loadstore step %0d: got %b expected %b", i, outs, tv[i].exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    step_t tv[$];
    for (int i = 0; i < 4; i++) tv.push_back(s(1, 0, 0, OP_R, 3'b000, F_WAIT, 2'b00));
    tv.push_back(s(1, 0, 0, OP_R, 3'b000, F_QUIET, 2'b00));
    tv.push_back(s(1, 0, 0, OP_R, 3'b000, HALT_V, 2'b01));
    tv.push_back(s(1, 1, 0, OP_R, 3'b000, HALT_V, 2'b01));
    tv.push_back(s(0, 0, 0, OP_R, 3'b000, HALT_V, 2'b01));
    for (int i = 0; i < 4; i++) tv.push_back(s(1, 0, 0, OP_R, 3'b000, F_WAIT, 2'b00));
    tv.push_back(s(1, 1, 0, OP_R, 3'b000, F_RDY, 2'b00));
    tv.push_back(s(1, 1, 0, OP_R, 3'b000, DEC, 2'b00));
    tv.push_back(s(1, 1, 0, OP_R, 3'b000, EXR_ALU, 2'b00));
    apply_reset();
    for (int i = 0; i < tv.size(); i++) begin
      reset = tv[i].rst; MemReady = tv[i].rdy; Zero = tv[i].zero; op = tv[i].op; funct3 = tv[i].f3;
      #1;
      checks++;
      if (outs !== tv[i].exp) begin
        fails++;
        $display("FAIL timeout step %0d: got %b expected %b", i, outs, tv[i].exp);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_jump();
    test_branch();
    test_load_store();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
